// File: rtl/window_collector.sv
// window_collector: builds a registered KxK sliding window from a raster pixel
// stream using K-1 line buffers, with stall support, stride 1/2, sof restart,
// frame-done signalling and configuration checking.
module window_collector #(
   parameter int DATA_W     = 8,
   parameter int MAX_WIDTH  = 128,
   parameter int MAX_HEIGHT = 128,
   parameter int K          = 3,
   localparam int CW = $clog2(MAX_WIDTH + 1),
   localparam int RW = $clog2(MAX_HEIGHT + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     pixel_in,
   input  logic                  pixel_valid,
   input  logic                  sof,
   input  logic [CW-1:0]         stage_width,
   input  logic [RW-1:0]         stage_height,
   input  logic                  stride_sel,
   output logic [K*K*DATA_W-1:0] window_out,
   output logic                  win_valid,
   output logic                  frame_done,
   output logic                  cfg_err
);

   localparam int IW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam logic [CW-1:0] MAXW_C = CW'(MAX_WIDTH);
   localparam logic [RW-1:0] MAXH_C = RW'(MAX_HEIGHT);
   localparam logic [CW-1:0] KW_C   = CW'(K);
   localparam logic [RW-1:0] KH_C   = RW'(K);
   localparam logic [CW-1:0] KM1_W  = CW'(K - 1);
   localparam logic [RW-1:0] KM1_H  = RW'(K - 1);

   // counters and latched frame configuration
   logic [CW-1:0] col;
   logic [CW-1:0] lat_w;
   logic [RW-1:0] row;
   logic [RW-1:0] lat_h;
   logic          lat_stride;

   // line buffers (index 0 = most recently shifted in) and window registers
   logic [DATA_W-1:0] lb       [K-1][MAX_WIDTH];
   logic [DATA_W-1:0] win      [K][K];
   logic [DATA_W-1:0] tap      [K-1];
   logic [DATA_W-1:0] feed     [K-1];
   logic [DATA_W-1:0] col_data [K];
   logic [IW-1:0]     tap_idx;

   // per-accept position and configuration in effect for the current pixel
   logic [CW-1:0] eff_w;
   logic [CW-1:0] cur_col;
   logic [RW-1:0] eff_h;
   logic [RW-1:0] cur_row;
   logic          eff_stride;
   logic          eff_err;
   logic          cfg_bad;
   logic          last_col;
   logic          last_row;
   logic          row_par;
   logic          col_par;
   logic          win_ok;

   // position/config of the pixel being accepted; an sof pixel uses the new config
   always_comb begin
      cfg_bad = (stage_width < KW_C) || (stage_width > MAXW_C) ||
                (stage_height < KH_C) || (stage_height > MAXH_C);
      if (sof) begin
         eff_w      = (stage_width > MAXW_C) ? MAXW_C :
                      (stage_width == '0) ? CW'(1) : stage_width;
         eff_h      = (stage_height > MAXH_C) ? MAXH_C :
                      (stage_height == '0) ? RW'(1) : stage_height;
         eff_stride = stride_sel;
         eff_err    = cfg_bad;
         cur_col    = '0;
         cur_row    = '0;
      end else begin
         eff_w      = lat_w;
         eff_h      = lat_h;
         eff_stride = lat_stride;
         eff_err    = cfg_err;
         cur_col    = col;
         cur_row    = row;
      end
      last_col = (cur_col == eff_w - CW'(1));
      last_row = (cur_row == eff_h - RW'(1));
      row_par  = cur_row[0] ^ KM1_H[0];
      col_par  = cur_col[0] ^ KM1_W[0];
      win_ok   = !eff_err && (cur_row >= KM1_H) && (cur_col >= KM1_W) &&
                 (!eff_stride || (!row_par && !col_par));
   end

   // line-buffer taps feed the next buffer and the new window column
   // (tap delay is a pure accept count, so using the pre-sof width on the sof
   // pixel only affects row 0, which never forms a window)
   always_comb begin
      tap_idx = IW'(lat_w - CW'(1));
      for (int unsigned j = 0; j < K - 1; j++) begin
         tap[j] = lb[j][tap_idx];
      end
      feed[0] = pixel_in;
      for (int unsigned j = 1; j < K - 1; j++) begin
         feed[j] = tap[j-1];
      end
      col_data[K-1] = pixel_in;
      for (int unsigned r = 0; r < K - 1; r++) begin
         col_data[r] = tap[K-2-r];
      end
   end

   // counters, config latch and output strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col        <= '0;
         row        <= '0;
         lat_w      <= MAXW_C;
         lat_h      <= MAXH_C;
         lat_stride <= 1'b0;
         cfg_err    <= 1'b0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (pixel_valid) begin
            if (sof) begin
               lat_w      <= eff_w;
               lat_h      <= eff_h;
               lat_stride <= eff_stride;
               cfg_err    <= eff_err;
            end
            win_valid <= win_ok;
            if (last_col) begin
               col <= '0;
               if (last_row) begin
                  row        <= '0;
                  frame_done <= 1'b1;
               end else begin
                  row <= cur_row + RW'(1);
               end
            end else begin
               col <= cur_col + CW'(1);
               row <= cur_row;
            end
         end
      end
   end

   // line buffers shift one entry per accepted pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned j = 0; j < K - 1; j++) begin
            for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
               lb[j][i] <= '0;
            end
         end
      end else if (pixel_valid) begin
         for (int unsigned j = 0; j < K - 1; j++) begin
            lb[j][0] <= feed[j];
            for (int unsigned i = 1; i < MAX_WIDTH; i++) begin
               lb[j][i] <= lb[j][i-1];
            end
         end
      end
   end

   // window rows shift left; the newest column enters at c = K-1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
               win[r][c] <= '0;
            end
         end
      end else if (pixel_valid) begin
         for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K - 1; c++) begin
               win[r][c] <= win[r][c+1];
            end
            win[r][K-1] <= col_data[r];
         end
      end
   end

   // flatten window: element r*K+c, r = 0 oldest row, c = 0 oldest column
   always_comb begin
      window_out = '0;
      for (int unsigned i = 0; i < K * K; i++) begin
         window_out[i*DATA_W +: DATA_W] = win[i/K][i%K];
      end
   end

endmodule

// File: tb/tb_window_collector.sv
// tb_window_collector: directed scenarios plus randomized frames, checked
// against a frame-array reference model of the sliding-window rules.
module tb_window_collector;

   localparam int DW = 8;
   localparam int MW = 16;
   localparam int MH = 16;
   localparam int K  = 3;
   localparam int CW = $clog2(MW + 1);
   localparam int RW = $clog2(MH + 1);
   localparam int WW = K * K * DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] pixel_in = '0;
   logic          pixel_valid = 1'b0;
   logic          sof = 1'b0;
   logic [CW-1:0] stage_width = '0;
   logic [RW-1:0] stage_height = '0;
   logic          stride_sel = 1'b0;
   logic [WW-1:0] window_out;
   logic          win_valid;
   logic          frame_done;
   logic          cfg_err;

   window_collector #(
      .DATA_W     (DW),
      .MAX_WIDTH  (MW),
      .MAX_HEIGHT (MH),
      .K          (K)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pixel_in     (pixel_in),
      .pixel_valid  (pixel_valid),
      .sof          (sof),
      .stage_width  (stage_width),
      .stage_height (stage_height),
      .stride_sel   (stride_sel),
      .window_out   (window_out),
      .win_valid    (win_valid),
      .frame_done   (frame_done),
      .cfg_err      (cfg_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model state
   int            m_w, m_h, m_s, m_idx;
   bit            m_err;
   logic [DW-1:0] fr [MH][MW];
   logic          e_valid, e_done, e_err;
   logic [WW-1:0] e_win;

   // per-scenario observations
   int            win_cnt, done_cnt;
   bit            got_first;
   logic [WW-1:0] first_win, last_win;

   task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [WW-1:0] win9(input int e0, input int e1, input int e2,
                                          input int e3, input int e4, input int e5,
                                          input int e6, input int e7, input int e8);
      return {DW'(e8), DW'(e7), DW'(e6), DW'(e5), DW'(e4), DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
   endfunction

   function automatic int clampi(input int v, input int hi);
      return (v > hi) ? hi : ((v < 1) ? 1 : v);
   endfunction

   task automatic model_reset();
      m_w = MW; m_h = MH; m_s = 1; m_idx = 0; m_err = 1'b0;
   endtask

   task automatic clear_stats();
      win_cnt = 0; done_cnt = 0; got_first = 1'b0;
      first_win = '0; last_win = '0;
   endtask

   // predicts the outputs the next clock edge must produce
   task automatic predict(input logic v, input logic s, input logic [DW-1:0] px);
      int r, c, sw, sh;
      e_valid = 1'b0;
      e_done  = 1'b0;
      e_win   = '0;
      if (v) begin
         if (s) begin
            sw = int'(stage_width);
            sh = int'(stage_height);
            m_err = (sw < K) || (sw > MW) || (sh < K) || (sh > MH);
            m_w   = clampi(sw, MW);
            m_h   = clampi(sh, MH);
            m_s   = stride_sel ? 2 : 1;
            m_idx = 0;
         end
         r = m_idx / m_w;
         c = m_idx % m_w;
         fr[r][c] = px;
         if (!m_err && r >= K-1 && c >= K-1 && ((r-(K-1)) % m_s) == 0 && ((c-(K-1)) % m_s) == 0) begin
            e_valid = 1'b1;
            for (int dr = 0; dr < K; dr++)
               for (int dc = 0; dc < K; dc++)
                  e_win[(dr*K+dc)*DW +: DW] = fr[r-(K-1)+dr][c-(K-1)+dc];
         end
         e_done = (m_idx == m_w * m_h - 1);
         m_idx  = e_done ? 0 : m_idx + 1;
      end
      e_err = m_err;
   endtask

   // drive one cycle at the falling edge, check results at the next falling edge
   task automatic step(input logic v, input logic s, input logic [DW-1:0] px);
      pixel_valid = v;
      sof         = s;
      pixel_in    = px;
      predict(v, s, px);
      @(negedge clk);
      check("win_valid", WW'(win_valid), WW'(e_valid));
      if (e_valid) check("window", window_out, e_win);
      check("frame_done", WW'(frame_done), WW'(e_done));
      check("cfg_err", WW'(cfg_err), WW'(e_err));
      if (win_valid) begin
         win_cnt++;
         if (!got_first) begin
            first_win = window_out;
            got_first = 1'b1;
         end
         last_win = window_out;
      end
      if (frame_done) done_cnt++;
   endtask

   task automatic set_cfg(input int w, input int h, input int stride);
      stage_width  = CW'(w);
      stage_height = RW'(h);
      stride_sel   = (stride == 2);
   endtask

   task automatic send_frame(input int w, input int h, input int stride, input int base,
                             input bit stall, input bit use_sof);
      set_cfg(w, h, stride);
      for (int n = 0; n < w * h; n++) begin
         step(1'b1, use_sof && (n == 0), DW'(base + n));
         if (stall && (n % 2 == 1)) repeat (3) step(1'b0, 1'b0, DW'($urandom));
      end
      step(1'b0, 1'b0, '0);
   endtask

   task automatic check_s1(input string pfx);
      check({pfx, "_count"}, WW'(win_cnt), WW'(4));
      check({pfx, "_first"}, first_win, win9(0, 1, 2, 4, 5, 6, 8, 9, 10));
      check({pfx, "_last"}, last_win, win9(5, 6, 7, 9, 10, 11, 13, 14, 15));
      check({pfx, "_done"}, WW'(done_cnt), WW'(1));
   endtask

   initial begin
      model_reset();
      clear_stats();
      repeat (2) @(negedge clk);
      check("rst_window", window_out, '0);
      check("rst_valid", WW'(win_valid), '0);
      check("rst_done", WW'(frame_done), '0);
      check("rst_cfg_err", WW'(cfg_err), '0);
      rst_n = 1'b1;

      // 1: 4x4 stride 1, back-to-back
      clear_stats();
      send_frame(4, 4, 1, 0, 1'b0, 1'b1);
      check_s1("s1");

      // 2: same frame with stalls
      clear_stats();
      send_frame(4, 4, 1, 0, 1'b1, 1'b1);
      check_s1("s2");

      // 3: 6x6 stride 2
      clear_stats();
      send_frame(6, 6, 2, 0, 1'b0, 1'b1);
      check("s3_count", WW'(win_cnt), WW'(4));
      check("s3_first", first_win, win9(0, 1, 2, 6, 7, 8, 12, 13, 14));
      check("s3_last", last_win, win9(14, 15, 16, 20, 21, 22, 26, 27, 28));

      // 4: frame aborted by sof at pixel 7
      clear_stats();
      set_cfg(4, 4, 1);
      for (int n = 0; n < 7; n++) step(1'b1, n == 0, DW'(n));
      send_frame(4, 4, 1, 100, 1'b0, 1'b1);
      check("s4_count", WW'(win_cnt), WW'(4));
      check("s4_done", WW'(done_cnt), WW'(1));
      check("s4_first", first_win, win9(100, 101, 102, 104, 105, 106, 108, 109, 110));

      // 5: asynchronous reset mid-frame, then scenario 1 again
      clear_stats();
      set_cfg(4, 4, 1);
      for (int n = 0; n < 10; n++) step(1'b1, n == 0, DW'(n));
      pixel_valid = 1'b0;
      sof = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("s5_rst_window", window_out, '0);
      check("s5_rst_valid", WW'(win_valid), '0);
      check("s5_rst_done", WW'(frame_done), '0);
      check("s5_rst_cfg_err", WW'(cfg_err), '0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      clear_stats();
      send_frame(4, 4, 1, 0, 1'b0, 1'b1);
      check_s1("s5");

      // 6: illegal width, then legal frame clears cfg_err
      clear_stats();
      send_frame(2, 4, 1, 50, 1'b0, 1'b1);
      check("s6_err_count", WW'(win_cnt), '0);
      check("s6_err_flag", WW'(cfg_err), WW'(1));
      clear_stats();
      send_frame(4, 4, 1, 0, 1'b0, 1'b1);
      check_s1("s6");

      // randomized frames: sizes, strides, stalls, optional sof, aborts
      for (int f = 0; f < 30; f++) begin
         int w, h, s, cnt;
         bit use_sof;
         w = $urandom_range(1, 18);
         h = $urandom_range(1, 9);
         s = ($urandom_range(0, 1) == 1) ? 2 : 1;
         use_sof = ($urandom_range(0, 3) != 0);
         set_cfg(w, h, s);
         cnt = use_sof ? clampi(w, MW) * clampi(h, MH) : m_w * m_h - m_idx;
         if ($urandom_range(0, 5) == 0) cnt = $urandom_range(1, cnt);
         for (int n = 0; n < cnt; n++) begin
            step(1'b1, use_sof && (n == 0), DW'($urandom));
            if ($urandom_range(0, 3) == 0)
               repeat ($urandom_range(1, 3)) step(1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
         end
      end
      repeat (2) step(1'b0, 1'b0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/window_collector.md
Name: window_collector

Overview:
- Parametrised successor to the fixed 3x3 8-bit window collector in the conv accelerator front end.
- Builds a KxK sliding window from a raster pixel stream using K-1 runtime-width line buffers.
- Adds per-pixel valid qualification (stalls), row/column tracking, "valid" convolution border handling, stride 1/2, start-of-frame restart and frame-done signalling.
- Feeds the MAC array with a registered window and a window-valid strobe.

Parameters:
- DATA_W, 8, pixel width in bits.
- MAX_WIDTH, 128, maximum line length; depth of each line buffer.
- MAX_HEIGHT, 128, maximum frame height.
- K, 3, kernel size; odd, legal range 3..7.
- CW = $clog2(MAX_WIDTH+1) and RW = $clog2(MAX_HEIGHT+1) are derived localparams.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- pixel_in  in  DATA_W  raster pixel.
- pixel_valid  in  1  pixel_in is accepted this cycle.
- sof  in  1  qualified by pixel_valid; this pixel is (row 0, col 0) of a new frame.
- stage_width  in  CW  line length in pixels; sampled at sof.
- stage_height  in  RW  frame height in rows; sampled at sof.
- stride_sel  in  1  0 = stride 1, 1 = stride 2; sampled at sof.
- window_out  out  K*K*DATA_W  window. Element i is at [i*DATA_W +: DATA_W]. i = r*K + c, with r = 0 for the oldest row and c = 0 for the oldest column. Element K*K-1 is the newest pixel.
- win_valid  out  1  window_out holds a new legal window (single-cycle pulse).
- frame_done  out  1  single-cycle pulse when the last pixel of the frame has been accepted.
- cfg_err  out  1  configuration sampled at the current sof is illegal; held until the next sof.

Behaviour:
Interface decision:
- Reset rst_n, asynchronous, active-low; clock clk.
- All state is in the clk domain.

Reset values:
- window_out = 0, win_valid = 0, frame_done = 0, cfg_err = 0.
- Column and row counters = 0; latched config = width MAX_WIDTH, height MAX_HEIGHT, stride 1.
- Line buffers and the window shift registers are cleared.
- While no pixel is accepted, nothing moves.

Accept cycle (pixel_valid = 1):
- Each of the K-1 line buffers shifts by one. Taps are at position stage_width-1; entries at index >= latched width are ignored.
- Each window row shifts left by one.
- New column K-1 is loaded with {linebuf[K-2] tap, ..., linebuf[0] tap, pixel_in}.
- Counter col increments; at latched_width-1 it wraps to 0 and row increments.
- pixel_valid = 0: line buffers, window and counters hold; win_valid and frame_done deassert.

sof:
- An accepted pixel with sof = 1 forces (row, col) = (0, 0) for that pixel.
- That same cycle it latches width, height and stride.
- Counters then advance normally.
- sof mid-frame abandons the current frame; no frame_done is issued for it.
- Line-buffer contents are not cleared; stale data is unreachable because windows require row >= K-1.

Window emission:
- win_valid is registered 1 cycle after the accepting edge of the pixel at (row, col).
- It asserts iff row >= K-1, col >= K-1, (row-(K-1)) mod stride = 0, (col-(K-1)) mod stride = 0, and cfg_err = 0.
- window_out updates on every accept. It is meaningful only when win_valid = 1.
- Windows never straddle a line wrap (col >= K-1 guarantees this).

frame_done:
- Pulses 1 cycle after accepting (latched_height-1, latched_width-1).
- Counters then return to (0, 0); the next frame may begin without sof.

cfg_err:
- Set at sof if width < K, width > MAX_WIDTH, height < K, or height > MAX_HEIGHT.
- While cfg_err = 1, pixels are still consumed and counters run (width clamped to MAX_WIDTH), but win_valid is suppressed.

Arithmetic:
- Counters are unsigned with no overflow beyond the latched bounds.
- Stride-2 parity uses the LSB of (row-(K-1)) and (col-(K-1)).

Test Plan:
1. K=3, width=4, height=4, stride 1, pixels 0..15 back-to-back with sof on pixel 0.
   - First win_valid 1 cycle after pixel 10, window = {0,1,2,4,5,6,8,9,10}.
   - Exactly 4 windows; the last is {5,6,7,9,10,11,13,14,15}.
   - frame_done 1 cycle after pixel 15.
2. Same as 1, with pixel_valid deasserted for 3 cycles after every second pixel.
   - Identical window sequence and count; no win_valid during stall cycles.
3. K=3, width=6, height=6, stride_sel=1, pixels 0..35.
   - Exactly 4 windows, centred at (1,1), (1,3), (3,1), (3,3).
   - First window = {0,1,2,6,7,8,12,13,14}.
4. sof reissued at pixel 7 of a 4x4 frame, then 16 fresh pixels 100..115.
   - No frame_done for the aborted frame; first window = {100,101,102,104,105,106,108,109,110}.
5. rst_n asserted mid-frame (after pixel 9).
   - All outputs 0 immediately (asynchronous).
   - After release, a new 4x4 frame reproduces scenario 1 exactly.
6. sof with stage_width=2, K=3.
   - cfg_err = 1 and no win_valid for the frame.
   - A following sof with width=4 clears cfg_err and windows resume.
